// File: rtl/clock_set_controller.sv
// Front-panel sequencer for the century clock: turns mode/inc button levels into
// run/display mode, per-field increment pulses, auto-repeat, blink and inactivity timeout.
module clock_set_controller #(
    parameter int unsigned HOLD_CYC   = 500,
    parameter int unsigned REPEAT_CYC = 100,
    parameter int unsigned TIMEOUT_S  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       run_mode,
    output logic       display_mode,
    output logic       manual_ss_yy_en,
    output logic       manual_min_mon_en,
    output logic       manual_hh_dd_en,
    output logic [2:0] field_sel,
    output logic       blink
);

    localparam int unsigned RepMax = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int unsigned RepW   = $clog2(RepMax + 1);
    localparam int unsigned IdleW  = $clog2(TIMEOUT_S + 1);

    localparam logic [RepW-1:0]  HoldVal    = RepW'(HOLD_CYC);
    localparam logic [RepW-1:0]  RepeatVal  = RepW'(REPEAT_CYC);
    localparam logic [IdleW-1:0] TimeoutVal = IdleW'(TIMEOUT_S);

    // Encoding doubles as the field_sel value.
    typedef enum logic [2:0] {
        StRun = 3'd0,
        StSs  = 3'd1,
        StMin = 3'd2,
        StHh  = 3'd3,
        StDd  = 3'd4,
        StMon = 3'd5,
        StYy  = 3'd6
    } state_e;

    // RepIdle: no armed press; RepHold: waiting out HOLD_CYC; RepRepeat: pulsing every REPEAT_CYC.
    typedef enum logic [1:0] {
        RepIdle,
        RepHold,
        RepRepeat
    } rep_e;

    state_e            state_q, state_d;
    rep_e              rep_q, rep_d;
    logic [RepW-1:0]   rep_cnt_q, rep_cnt_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic              mode_q, mode_d;
    logic              inc_q, inc_d;
    logic              run_mode_q, run_mode_d;
    logic              disp_q, disp_d;
    logic              ss_yy_q, ss_yy_d;
    logic              min_mon_q, min_mon_d;
    logic              hh_dd_q, hh_dd_d;
    logic              blink_q, blink_d;

    logic              mode_press, inc_press, pulse;

    assign mode_press = btn_mode & ~mode_q;
    assign inc_press  = btn_inc & ~inc_q;

    // Next-state: field sequencing, increment/auto-repeat, timeout and blink.
    always_comb begin
        state_d   = state_q;
        rep_d     = rep_q;
        rep_cnt_d = rep_cnt_q;
        idle_d    = idle_q;
        mode_d    = btn_mode;
        inc_d     = btn_inc;
        disp_d    = disp_q;
        blink_d   = blink_q;
        pulse     = 1'b0;
        ss_yy_d   = 1'b0;
        min_mon_d = 1'b0;
        hh_dd_d   = 1'b0;

        if (mode_press) begin
            // Mode wins over a simultaneous inc press.
            state_d = (state_q == StYy) ? StRun : state_e'(state_q + 3'd1);
        end else if (state_q == StRun) begin
            if (inc_press) begin
                disp_d = ~disp_q;
            end
        end else begin
            if (inc_press) begin
                pulse     = 1'b1;
                rep_d     = RepHold;
                rep_cnt_d = '0;
            end else if (!btn_inc) begin
                rep_d     = RepIdle;
                rep_cnt_d = '0;
            end else if (rep_q != RepIdle) begin
                rep_cnt_d = rep_cnt_q + 1'b1;
                if ((rep_q == RepHold && rep_cnt_d == HoldVal) ||
                    (rep_q == RepRepeat && rep_cnt_d == RepeatVal)) begin
                    pulse     = 1'b1;
                    rep_d     = RepRepeat;
                    rep_cnt_d = '0;
                end
            end

            if (btn_inc) begin
                idle_d = '0;
            end else if (tick_1hz) begin
                idle_d = idle_q + 1'b1;
                if (idle_d == TimeoutVal) begin
                    state_d = StRun;
                end
            end

            if (tick_1hz) begin
                blink_d = ~blink_q;
            end
        end

        // Any field change restarts blink, idle and repeat tracking.
        if (state_d != state_q) begin
            rep_d     = RepIdle;
            rep_cnt_d = '0;
            idle_d    = '0;
            blink_d   = 1'b0;
            pulse     = 1'b0;
            disp_d    = (state_d == StDd) || (state_d == StMon) || (state_d == StYy);
        end

        if (pulse) begin
            case (state_q)
                StSs, StYy:  ss_yy_d   = 1'b1;
                StMin, StMon: min_mon_d = 1'b1;
                StHh, StDd:  hh_dd_d   = 1'b1;
                default:     ;
            endcase
        end

        run_mode_d = (state_d != StRun);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StRun;
            rep_q      <= RepIdle;
            rep_cnt_q  <= '0;
            idle_q     <= '0;
            mode_q     <= 1'b1;
            inc_q      <= 1'b1;
            run_mode_q <= 1'b0;
            disp_q     <= 1'b0;
            ss_yy_q    <= 1'b0;
            min_mon_q  <= 1'b0;
            hh_dd_q    <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rep_q      <= rep_d;
            rep_cnt_q  <= rep_cnt_d;
            idle_q     <= idle_d;
            mode_q     <= mode_d;
            inc_q      <= inc_d;
            run_mode_q <= run_mode_d;
            disp_q     <= disp_d;
            ss_yy_q    <= ss_yy_d;
            min_mon_q  <= min_mon_d;
            hh_dd_q    <= hh_dd_d;
            blink_q    <= blink_d;
        end
    end

    assign run_mode          = run_mode_q;
    assign display_mode      = disp_q;
    assign manual_ss_yy_en   = ss_yy_q;
    assign manual_min_mon_en = min_mon_q;
    assign manual_hh_dd_en   = hh_dd_q;
    assign field_sel         = state_q;
    assign blink             = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed scenarios followed by random button/tick
// traffic, all checked every cycle against an event-level reference model.
module tb_clock_set_controller;

    localparam int unsigned Hold = 5;
    localparam int unsigned Rep  = 3;
    localparam int unsigned Tmo  = 3;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, btn_mode, btn_inc;
    logic       run_mode, display_mode;
    logic       manual_ss_yy_en, manual_min_mon_en, manual_hh_dd_en;
    logic [2:0] field_sel;
    logic       blink;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: field index 0..6, plain integer counters.
    int   m_field;
    bit   m_disp, m_blink, m_prev_mode, m_prev_inc;
    bit   m_en [3];
    int   m_held;   // cycles held since an armed inc press, -1 when not armed
    int   m_idle;   // ticks since last activity

    clock_set_controller #(
        .HOLD_CYC  (Hold),
        .REPEAT_CYC(Rep),
        .TIMEOUT_S (Tmo)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tick_1hz         (tick_1hz),
        .btn_mode         (btn_mode),
        .btn_inc          (btn_inc),
        .run_mode         (run_mode),
        .display_mode     (display_mode),
        .manual_ss_yy_en  (manual_ss_yy_en),
        .manual_min_mon_en(manual_min_mon_en),
        .manual_hh_dd_en  (manual_hh_dd_en),
        .field_sel        (field_sel),
        .blink            (blink)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Field -> enable index: seconds/year 0, minute/month 1, hour/day 2.
    function automatic int en_index(input int f);
        return (f <= 3) ? f - 1 : 6 - f;
    endfunction

    task automatic model_step(input bit r, input bit t, input bit bm, input bit bi);
        bit mp, ip, fire;
        int nf;
        for (int i = 0; i < 3; i++) m_en[i] = 1'b0;
        if (!r) begin
            m_field = 0; m_disp = 0; m_blink = 0; m_prev_mode = 1; m_prev_inc = 1;
            m_held = -1; m_idle = 0;
            return;
        end
        mp = bm && !m_prev_mode;
        ip = bi && !m_prev_inc;
        m_prev_mode = bm;
        m_prev_inc  = bi;
        nf = m_field;
        fire = 0;
        if (mp) begin
            nf = (m_field + 1) % 7;
        end else if (m_field == 0) begin
            if (ip) m_disp = !m_disp;
        end else begin
            if (ip) begin
                fire = 1; m_held = 0;
            end else if (!bi) begin
                m_held = -1;
            end else if (m_held >= 0) begin
                m_held++;
                if (m_held == Hold || (m_held > Hold && (m_held - Hold) % Rep == 0)) fire = 1;
            end
            if (bi) m_idle = 0;
            else if (t) begin
                m_idle++;
                if (m_idle == Tmo) nf = 0;
            end
            if (t) m_blink = !m_blink;
        end
        if (nf != m_field) begin
            m_held = -1; m_idle = 0; m_blink = 0; fire = 0;
            m_disp = (nf >= 4);
        end else if (fire) begin
            m_en[en_index(m_field)] = 1'b1;
        end
        m_field = nf;
    endtask

    task automatic check_outputs();
        check_val("field_sel", 32'(field_sel), 32'(m_field));
        check_val("run_mode", 32'(run_mode), 32'(m_field != 0));
        check_val("display_mode", 32'(display_mode), 32'(m_disp));
        check_val("ss_yy_en", 32'(manual_ss_yy_en), 32'(m_en[0]));
        check_val("min_mon_en", 32'(manual_min_mon_en), 32'(m_en[1]));
        check_val("hh_dd_en", 32'(manual_hh_dd_en), 32'(m_en[2]));
        check_val("blink", 32'(blink), 32'(m_blink));
    endtask

    // Drive one cycle of inputs, advance the model, check after the edge.
    task automatic cyc(input bit r, input bit t, input bit bm, input bit bi);
        rst = r; tick_1hz = t; btn_mode = bm; btn_inc = bi;
        model_step(r, t, bm, bi);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic press_mode(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 1, 0);
            cyc(1, 0, 0, 0);
        end
    endtask

    initial begin
        // Mode held through reset must not count as a press.
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        repeat (3) cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);            // -> SS
        cyc(1, 0, 0, 0);
        press_mode(6);              // back to RUN
        // RUN: inc toggles the view.
        repeat (2) begin
            cyc(1, 0, 0, 1);
            cyc(1, 0, 0, 0);
        end
        // MON, single inc press.
        press_mode(5);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        press_mode(2);              // MON -> YY -> RUN
        // SS, inc held for auto-repeat.
        press_mode(1);
        repeat (15) cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        // HH timeout after three ticks.
        press_mode(2);
        repeat (3) begin
            cyc(1, 1, 0, 0);
            cyc(1, 0, 0, 0);
        end
        // HH again; inc press on the third tick keeps the field.
        press_mode(3);
        repeat (2) begin
            cyc(1, 1, 0, 0);
            cyc(1, 0, 0, 0);
        end
        cyc(1, 1, 0, 1);
        cyc(1, 0, 0, 0);
        // DD: simultaneous mode and inc press.
        press_mode(1);
        cyc(1, 0, 1, 1);
        cyc(1, 0, 0, 0);
        // YY: reset in the middle of a repeat.
        press_mode(1);
        repeat (7) cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);

        // Random traffic: button levels held for random segments.
        for (int s = 0; s < 600; s++) begin
            int  len;
            bit  bm, bi;
            len = $urandom_range(1, 20);
            bm  = ($urandom_range(0, 3) == 0);
            bi  = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < len; k++) begin
                cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) == 0), bm, bi);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
